// File: rtl/dual_port_ram_32x1024.sv
// Simple dual-port RAM: port A write-only, port B read-only with a registered
// output, one shared clock. Read-during-write to the same address is read-first.
module dual_port_ram_32x1024 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clka,
    input  logic                  rstn,
    input  logic                  ena,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    input  logic                  enb,
    input  logic [ADDR_WIDTH-1:0] addrb,
    output logic [DATA_WIDTH-1:0] doutb
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    // Storage and output register start at zero, matching the block RAM's
    // configured contents; reset never touches the array.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
    logic [DATA_WIDTH-1:0] doutb_q     = '0;

    // Port A write; deliberately independent of rstn.
    always_ff @(posedge clka) begin
        if (ena && wea) begin
            mem[addra] <= dina;
        end
    end

    // Port B registered read; sampling mem before the same-edge write lands
    // gives read-first behaviour on an address collision.
    always_ff @(posedge clka) begin
        if (!rstn) begin
            doutb_q <= '0;
        end else if (enb) begin
            doutb_q <= mem[addrb];
        end
    end

    assign doutb = doutb_q;

endmodule

// File: tb/tb_dual_port_ram_32x1024.sv
// Directed, scoreboard-checked bench for dual_port_ram_32x1024.
module tb_dual_port_ram_32x1024;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 10;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clka = 1'b0;
    logic          rstn;
    logic          ena;
    logic          wea;
    logic [AW-1:0] addra;
    logic [DW-1:0] dina;
    logic          enb;
    logic [AW-1:0] addrb;
    logic [DW-1:0] doutb;

    int checks   = 0;
    int failures = 0;

    // Behavioural reference: shadow array plus expected output register.
    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] model_dout;

    // Scoreboard of expected doutb values, pushed at drive time.
    logic [DW-1:0] exp_q [$];
    string         tag_q [$];

    dual_port_ram_32x1024 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clka (clka),
        .rstn (rstn),
        .ena  (ena),
        .wea  (wea),
        .addra(addra),
        .dina (dina),
        .enb  (enb),
        .addrb(addrb),
        .doutb(doutb)
    );

    always #5 clka = ~clka;

    task automatic check_now(input string tag, input logic [DW-1:0] expv);
        checks++;
        assert (doutb === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, doutb, expv);
        end
    endtask

    // One clock: drive inputs, push the model's expected doutb, clock, pop and compare.
    task automatic cyc(input string tag, input logic r, input logic ea, input logic wa,
                       input logic [AW-1:0] aa, input logic [DW-1:0] da,
                       input logic eb, input logic [AW-1:0] ab);
        logic [DW-1:0] e;
        string         t;
        rstn  = r;
        ena   = ea;
        wea   = wa;
        addra = aa;
        dina  = da;
        enb   = eb;
        addrb = ab;
        if (!r)      model_dout = '0;
        else if (eb) model_dout = model_mem[ab];
        if (ea && wa) model_mem[aa] = da;
        exp_q.push_back(model_dout);
        tag_q.push_back(tag);
        @(posedge clka);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check_now(t, e);
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = '0;
        model_dout = '0;
        rstn = 1'b1; ena = 1'b0; wea = 1'b0; addra = '0; dina = '0; enb = 1'b0; addrb = '0;
        #1;
        check_now("power_up_doutb", 32'h0);

        cyc("reset", 1'b0, 1'b0, 1'b0, 10'h000, 32'h0, 1'b1, 10'h000);
        check_now("reset_const", 32'h0);

        // Basic write/read at both ends of the address range
        cyc("wr_0",   1'b1, 1'b1, 1'b1, 10'h000, 32'hDEADBEEF, 1'b0, 10'h000);
        cyc("wr_3ff", 1'b1, 1'b1, 1'b1, 10'h3FF, 32'h12345678, 1'b0, 10'h000);
        cyc("rd_0",   1'b1, 1'b0, 1'b0, 10'h000, 32'h0, 1'b1, 10'h000);
        check_now("rd_0_const", 32'hDEADBEEF);
        cyc("rd_3ff", 1'b1, 1'b0, 1'b0, 10'h000, 32'h0, 1'b1, 10'h3FF);
        check_now("rd_3ff_const", 32'h12345678);

        // Write with ena=0 must not land
        cyc("wr_ena0", 1'b1, 1'b0, 1'b1, 10'd5, 32'hAAAA5555, 1'b0, 10'h000);
        cyc("rd_5",    1'b1, 1'b0, 1'b0, 10'h000, 32'h0, 1'b1, 10'd5);
        check_now("ena0_const", 32'h0);

        // enb=0 holds the output register
        cyc("rd_0b",  1'b1, 1'b0, 1'b0, 10'h000, 32'h0, 1'b1, 10'h000);
        cyc("enb0",   1'b1, 1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 10'h3FF);
        check_now("enb0_hold_const", 32'hDEADBEEF);

        // Read-first collision
        cyc("pre_7",   1'b1, 1'b1, 1'b1, 10'd7, 32'h11111111, 1'b0, 10'h000);
        cyc("coll_7",  1'b1, 1'b1, 1'b1, 10'd7, 32'h22222222, 1'b1, 10'd7);
        check_now("coll_old_const", 32'h11111111);
        cyc("after_7", 1'b1, 1'b0, 1'b0, 10'd0, 32'h0, 1'b1, 10'd7);
        check_now("coll_new_const", 32'h22222222);

        // Reset mid-operation with a concurrent write
        cyc("rd_0c",   1'b1, 1'b0, 1'b0, 10'h000, 32'h0, 1'b1, 10'h000);
        cyc("rst_wr",  1'b0, 1'b1, 1'b1, 10'd3, 32'hCAFEF00D, 1'b1, 10'h000);
        check_now("rst_mid_const", 32'h0);
        cyc("rd_3",    1'b1, 1'b0, 1'b0, 10'h000, 32'h0, 1'b1, 10'd3);
        check_now("rst_wr_kept_const", 32'hCAFEF00D);
        cyc("rd_0d",   1'b1, 1'b0, 1'b0, 10'h000, 32'h0, 1'b1, 10'h000);
        check_now("rst_mem_intact_const", 32'hDEADBEEF);
        cyc("rd_7b",   1'b1, 1'b0, 1'b0, 10'h000, 32'h0, 1'b1, 10'd7);

        // Simultaneous write and read at different addresses
        cyc("pre_200", 1'b1, 1'b1, 1'b1, 10'd200, 32'hF0F0F0F0, 1'b0, 10'h000);
        cyc("wr100_rd200", 1'b1, 1'b1, 1'b1, 10'd100, 32'h0F0F0F0F, 1'b1, 10'd200);
        check_now("diff_addr_rd_const", 32'hF0F0F0F0);
        cyc("rd_100",  1'b1, 1'b0, 1'b0, 10'h000, 32'h0, 1'b1, 10'd100);
        check_now("diff_addr_wr_const", 32'h0F0F0F0F);

        // Streaming fill then back-to-back readback
        for (int i = 0; i < int'(DEPTH); i++) begin
            logic [15:0] h;
            h = 16'(i);
            cyc("stream_wr", 1'b1, 1'b1, 1'b1, AW'(i), {h, ~h}, 1'b0, 10'h000);
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            logic [15:0] h;
            h = 16'(i);
            cyc("stream_rd", 1'b1, 1'b0, 1'b0, 10'h000, 32'h0, 1'b1, AW'(i));
            check_now("stream_rd_formula", {h, ~h});
        end

        // Rollover 1023 -> 0 is just two ordinary reads
        cyc("roll_3ff", 1'b1, 1'b0, 1'b0, 10'h000, 32'h0, 1'b1, 10'h3FF);
        cyc("roll_000", 1'b1, 1'b0, 1'b0, 10'h000, 32'h0, 1'b1, 10'h000);
        check_now("roll_000_const", 32'h0000FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
